dtw_batch_sched: RTL and testbench

Batch scheduler that sequences the DTW core over a run of back-to-back queries. It sits between the AXI-Lite register file and `dtw_core`. For each query it does four things in order: pulses the core reset, waits for squiggle data in the AXIS FIFO, holds start until the core reports done, and emits one result record. It also tracks the best (minimum) score across the batch and flags hits below a threshold. A watchdog aborts a hung run.

---
 rtl/dtw_batch_sched_if.sv | 23 ++
 rtl/dtw_batch_sched.sv | 197 +++++++++++++++++++
 tb/tb_dtw_batch_sched.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_batch_sched_if.sv
// Result-record stream from the batch scheduler to its consumer.
// The master side drives the record and valid; the slave side returns ready.
interface dtw_batch_sched_if #(
   parameter int unsigned axi_dwidth = 32,
   parameter int unsigned CNT_W      = 16
);
   logic                  res_valid;
   logic                  res_ready;
   logic [CNT_W-1:0]      res_idx;
   logic [axi_dwidth-1:0] res_minval;
   logic [axi_dwidth-1:0] res_pos;
   logic                  res_hit;

   modport master (
      output res_valid, res_idx, res_minval, res_pos, res_hit,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_idx, res_minval, res_pos, res_hit,
      output res_ready
   );
endinterface

// File: rtl/dtw_batch_sched.sv
// Sequences the DTW core over a batch of queries: clear, wait for data, run, emit one record.
// Tracks the batch minimum, flags threshold hits and aborts hung runs via a watchdog.
module dtw_batch_sched #(
   parameter int unsigned axi_dwidth = 32,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RST_CYC    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_go,
   input  logic                  cfg_abort,
   input  logic [CNT_W-1:0]      cfg_nq,
   input  logic                  cfg_mode,
   input  logic [axi_dwidth-1:0] cfg_thresh,
   input  logic [31:0]           cfg_timeout,
   output logic                  busy,
   output logic                  batch_done,
   output logic                  err_timeout,
   output logic                  core_rst,
   output logic                  core_start,
   output logic                  core_mode,
   input  logic                  core_done,
   input  logic [axi_dwidth-1:0] core_minval,
   input  logic [axi_dwidth-1:0] core_pos,
   input  logic                  fifo_empty,
   dtw_batch_sched_if.master     res,
   output logic [axi_dwidth-1:0] best_minval,
   output logic [axi_dwidth-1:0] best_pos,
   output logic [CNT_W-1:0]      best_idx
);

   localparam int unsigned RcW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   typedef enum logic [2:0] {StIdle, StClr, StWait, StRun, StEmit} st_e;

   st_e                   state_q, state_d;
   logic [RcW-1:0]        rc_q, rc_d;
   logic [31:0]           wd_q, wd_d, wd_inc;
   logic [CNT_W-1:0]      nq_q, nq_d, idx_q, idx_d;
   logic                  mode_q, mode_d;
   logic [axi_dwidth-1:0] thresh_q, thresh_d;
   logic [31:0]           tmo_q, tmo_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                  crst_q, crst_d, cstart_q, cstart_d, rvalid_q, rvalid_d;
   logic [axi_dwidth-1:0] rmin_q, rmin_d, rpos_q, rpos_d;
   logic                  rhit_q, rhit_d;
   logic [axi_dwidth-1:0] bmin_q, bmin_d, bpos_q, bpos_d;
   logic [CNT_W-1:0]      bidx_q, bidx_d;
   logic                  go_ok, run_done, wd_exp, hs, last;

   // Abort outranks every other event, including a go or a handshake in the same cycle.
   assign wd_inc   = (wd_q == '1) ? wd_q : wd_q + 32'd1;
   assign go_ok    = cfg_go && (state_q == StIdle) && !cfg_abort;
   assign run_done = (state_q == StRun) && core_done && !cfg_abort;
   assign wd_exp   = (state_q == StRun) && !core_done && !cfg_abort &&
                     (tmo_q != 32'd0) && (wd_inc >= tmo_q);
   assign hs       = (state_q == StEmit) && rvalid_q && res.res_ready && !cfg_abort;
   assign last     = (idx_q == nq_q - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cfg_abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: if (go_ok && (cfg_nq != '0)) state_d = StClr;
            StClr:  if (rc_q == RcW'(RST_CYC - 1)) state_d = StWait;
            StWait: if (!fifo_empty) state_d = StRun;
            StRun: begin
               if (run_done)    state_d = StEmit;
               else if (wd_exp) state_d = StIdle;
            end
            StEmit: if (hs) state_d = last ? StIdle : StClr;
            default: state_d = StIdle;
         endcase
      end
   end

   // Core controls and busy are registered copies of the next-state decode.
   always_comb begin
      busy_d   = (state_d != StIdle);
      cstart_d = (state_d == StRun);
      rvalid_d = (state_d == StEmit);
      crst_d   = (state_d == StClr) || wd_exp || (cfg_abort && (state_q != StIdle));
   end

   always_comb begin
      rc_d     = (state_q == StClr && state_d == StClr) ? rc_q + RcW'(1) : '0;
      wd_d     = (state_q == StRun && state_d == StRun) ? wd_inc : '0;
      nq_d     = nq_q;
      mode_d   = mode_q;
      thresh_d = thresh_q;
      tmo_d    = tmo_q;
      idx_d    = idx_q;
      done_d   = done_q;
      err_d    = err_q;
      rmin_d   = rmin_q;
      rpos_d   = rpos_q;
      rhit_d   = rhit_q;
      bmin_d   = bmin_q;
      bpos_d   = bpos_q;
      bidx_d   = bidx_q;
      if (go_ok) begin
         nq_d     = cfg_nq;
         mode_d   = cfg_mode;
         thresh_d = cfg_thresh;
         tmo_d    = cfg_timeout;
         idx_d    = '0;
         done_d   = (cfg_nq == '0);
         err_d    = 1'b0;
         bmin_d   = '1;
         bpos_d   = '0;
         bidx_d   = '0;
      end
      if (wd_exp) err_d = 1'b1;
      if (run_done) begin
         rmin_d = core_minval;
         rpos_d = core_pos;
         rhit_d = (core_minval < thresh_q);
      end
      if (hs) begin
         // Strict compare so ties keep the earlier index.
         if (rmin_q < bmin_q) begin
            bmin_d = rmin_q;
            bpos_d = rpos_q;
            bidx_d = idx_q;
         end
         if (last) done_d = 1'b1;
         else      idx_d  = idx_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rc_q     <= '0;
         wd_q     <= '0;
         nq_q     <= '0;
         mode_q   <= 1'b0;
         thresh_q <= '0;
         tmo_q    <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         crst_q   <= 1'b1;
         cstart_q <= 1'b0;
         rvalid_q <= 1'b0;
         rmin_q   <= '0;
         rpos_q   <= '0;
         rhit_q   <= 1'b0;
         bmin_q   <= '1;
         bpos_q   <= '0;
         bidx_q   <= '0;
      end else begin
         rc_q     <= rc_d;
         wd_q     <= wd_d;
         nq_q     <= nq_d;
         mode_q   <= mode_d;
         thresh_q <= thresh_d;
         tmo_q    <= tmo_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         crst_q   <= crst_d;
         cstart_q <= cstart_d;
         rvalid_q <= rvalid_d;
         rmin_q   <= rmin_d;
         rpos_q   <= rpos_d;
         rhit_q   <= rhit_d;
         bmin_q   <= bmin_d;
         bpos_q   <= bpos_d;
         bidx_q   <= bidx_d;
      end
   end

   assign busy           = busy_q;
   assign batch_done     = done_q;
   assign err_timeout    = err_q;
   assign core_rst       = crst_q;
   assign core_start     = cstart_q;
   assign core_mode      = mode_q;
   assign res.res_valid  = rvalid_q;
   assign res.res_idx    = idx_q;
   assign res.res_minval = rmin_q;
   assign res.res_pos    = rpos_q;
   assign res.res_hit    = rhit_q;
   assign best_minval    = bmin_q;
   assign best_pos       = bpos_q;
   assign best_idx       = bidx_q;

endmodule

// File: tb/tb_dtw_batch_sched.sv
// Directed bench for dtw_batch_sched with a small behavioural DTW core that
// raises done after a programmable number of run cycles.
module tb_dtw_batch_sched;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_go = 1'b0, cfg_abort = 1'b0, cfg_mode = 1'b0;
   logic [CW-1:0] cfg_nq = '0;
   logic [DW-1:0] cfg_thresh = '0;
   logic [31:0]   cfg_timeout = '0;
   logic          busy, batch_done, err_timeout, core_rst, core_start, core_mode;
   logic          core_done;
   logic [DW-1:0] core_minval = '0, core_pos = '0;
   logic          fifo_empty = 1'b0;
   logic [DW-1:0] best_minval, best_pos;
   logic [CW-1:0] best_idx;

   int            n_checks = 0;
   int            n_err = 0;
   int            run_cnt = 0;
   int            done_after = 10;
   logic          done_en = 1'b1;

   dtw_batch_sched_if #(.axi_dwidth(DW), .CNT_W(CW)) res_if ();

   dtw_batch_sched #(.axi_dwidth(DW), .CNT_W(CW), .RST_CYC(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_go      (cfg_go),
      .cfg_abort   (cfg_abort),
      .cfg_nq      (cfg_nq),
      .cfg_mode    (cfg_mode),
      .cfg_thresh  (cfg_thresh),
      .cfg_timeout (cfg_timeout),
      .busy        (busy),
      .batch_done  (batch_done),
      .err_timeout (err_timeout),
      .core_rst    (core_rst),
      .core_start  (core_start),
      .core_mode   (core_mode),
      .core_done   (core_done),
      .core_minval (core_minval),
      .core_pos    (core_pos),
      .fifo_empty  (fifo_empty),
      .res         (res_if.master),
      .best_minval (best_minval),
      .best_pos    (best_pos),
      .best_idx    (best_idx)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (!core_start) run_cnt <= 0;
      else             run_cnt <= run_cnt + 1;
   end
   assign core_done = done_en && core_start && (run_cnt == done_after - 1);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_batch(input logic [CW-1:0] nq, input logic [DW-1:0] th,
                              input logic [31:0] tmo);
      cfg_nq      = nq;
      cfg_thresh  = th;
      cfg_timeout = tmo;
      cfg_go      = 1'b1;
      tick();
      cfg_go      = 1'b0;
   endtask

   // Waits for a record, returning how many core_start cycles preceded it.
   task automatic wait_rec(output int runs);
      int k;
      runs = 0;
      k = 0;
      while (!res_if.res_valid && k < 200) begin
         if (core_start) runs++;
         k++;
         tick();
      end
      check("rec_valid", res_if.res_valid, 1);
   endtask

   task automatic wait_start();
      int k;
      k = 0;
      while (!core_start && k < 50) begin
         k++;
         tick();
      end
      check("start_seen", core_start, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] mv_tab [3];
      int            n, runs;
      logic          acc, ok;
      mv_tab[0] = 50;
      mv_tab[1] = 20;
      mv_tab[2] = 20;
      res_if.res_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_core_rst", core_rst, 1);
      check("rst_best_minval", best_minval, 32'hFFFF_FFFF);
      check("rst_busy", busy, 0);
      check("rst_valid", res_if.res_valid, 0);
      check("rst_start", core_start, 0);
      rst = 1'b0;
      tick();
      check("post_rst_core_rst", core_rst, 0);

      // Zero-length batch
      start_batch(0, 0, 0);
      check("zero_done", batch_done, 1);
      check("zero_busy", busy, 0);
      acc = 1'b0;
      repeat (4) begin
         acc = acc | core_rst | core_start;
         tick();
      end
      check("zero_no_pulse", acc, 0);

      // Normal batch of three
      cfg_mode = 1'b1;
      start_batch(3, 0, 0);
      check("go_clears_done", batch_done, 0);
      check("core_mode", core_mode, 1);
      check("go_to_rst", core_rst, 1);
      for (int q = 0; q < 3; q++) begin
         core_minval = mv_tab[q];
         core_pos    = 1000 + q;
         n = 0;
         while (core_rst && n < 20) begin
            n++;
            tick();
         end
         check("rst_len", n, 2);
         check("wait_no_start", core_start, 0);
         wait_rec(runs);
         check("run_len", runs, 10);
         check("rec_idx", res_if.res_idx, q);
         check("rec_minval", res_if.res_minval, mv_tab[q]);
         check("rec_pos", res_if.res_pos, 1000 + q);
         tick();
         if (q < 2) check("hs_to_rst", core_rst, 1);
      end
      check("batch_done", batch_done, 1);
      check("batch_busy", busy, 0);
      check("best_minval", best_minval, 20);
      check("best_idx", best_idx, 1);
      check("best_pos", best_pos, 1001);

      // Data wait, backpressure, threshold equal to minval
      cfg_mode    = 1'b0;
      fifo_empty  = 1'b1;
      core_minval = 100;
      core_pos    = 7;
      res_if.res_ready = 1'b0;
      start_batch(1, 100, 0);
      tick();
      tick();
      acc = 1'b0;
      repeat (7) begin
         acc = acc | core_start;
         tick();
      end
      check("fifo_hold_start", acc, 0);
      fifo_empty = 1'b0;
      tick();
      check("fifo_release_start", core_start, 1);
      wait_rec(runs);
      check("bp_run_len", runs, 10);
      check("hit_equal", res_if.res_hit, 0);
      ok = 1'b1;
      repeat (5) begin
         tick();
         ok = ok & res_if.res_valid & (res_if.res_minval == 100) & !core_rst;
      end
      check("bp_stable", ok, 1);
      res_if.res_ready = 1'b1;
      tick();
      check("bp_done", batch_done, 1);
      check("bp_no_rst", core_rst, 0);
      check("bp_best", best_minval, 100);

      // Threshold hit, go while busy ignored
      core_minval = 99;
      start_batch(1, 100, 0);
      tick();
      cfg_nq = 5;
      cfg_go = 1'b1;
      tick();
      cfg_go = 1'b0;
      wait_rec(runs);
      check("hit_below", res_if.res_hit, 1);
      check("busy_go_idx", res_if.res_idx, 0);
      tick();
      check("busy_go_done", batch_done, 1);
      check("busy_go_idle", busy, 0);

      // Done and watchdog expiry in the same cycle
      core_minval = 5;
      start_batch(1, 0, 10);
      wait_rec(runs);
      check("tie_run_len", runs, 10);
      check("tie_no_err", err_timeout, 0);
      tick();
      check("tie_done", batch_done, 1);
      check("tie_no_err2", err_timeout, 0);

      // Watchdog timeout
      done_en = 1'b0;
      start_batch(2, 0, 16);
      wait_start();
      n = 0;
      acc = 1'b0;
      while (core_start && n < 100) begin
         n++;
         acc = acc | res_if.res_valid;
         tick();
      end
      check("tmo_run_len", n, 16);
      check("tmo_err", err_timeout, 1);
      check("tmo_rst", core_rst, 1);
      check("tmo_idle", busy, 0);
      check("tmo_no_done", batch_done, 0);
      tick();
      check("tmo_rst_1cyc", core_rst, 0);
      check("tmo_no_rec", acc | res_if.res_valid, 0);
      done_en = 1'b1;

      // Abort during query 1 of 4, then restart
      core_minval = 77;
      start_batch(4, 0, 0);
      check("go_clears_err", err_timeout, 0);
      wait_rec(runs);
      tick();
      core_minval = 33;
      wait_start();
      repeat (3) tick();
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      check("abort_idle", busy, 0);
      check("abort_start", core_start, 0);
      check("abort_rst", core_rst, 1);
      check("abort_valid", res_if.res_valid, 0);
      check("abort_flags", {batch_done, err_timeout}, 0);
      check("abort_best_hold", best_minval, 77);
      tick();
      check("abort_rst_1cyc", core_rst, 0);
      core_minval = 55;
      start_batch(1, 0, 0);
      wait_rec(runs);
      check("restart_idx", res_if.res_idx, 0);
      tick();
      check("restart_done", batch_done, 1);
      check("restart_best", best_minval, 55);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
